// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache: address fields and fill FSM states.
package cpu_types_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    // Field split of a fetch address for the default 16-frame geometry.
    typedef struct packed {
        logic [25:0] tag;
        logic [3:0]  idx;
        logic [1:0]  bytoff;
    } icachef_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
interface icache_if;

    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache_frame_array.sv
// Valid/tag/data storage: one async read port, one sync write port.
module icache_frame_array #(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
    output logic [31:0]      rd_data_o,
    input  logic             we_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic [31:0]      wr_data_i
);

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag/data carry no reset; valid alone qualifies them.
    always_ff @(posedge clk_i) begin
        if (we_i && rst_ni) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one word per block.
module icache
    import cpu_types_pkg::*;
#(
    parameter int          SETS    = 16,
    parameter logic [31:0] PC_INIT = 32'h0
) (
    input  logic     CLK,
    input  logic     nRST,
    icache_if.slave  ibus
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - IDX_W;

    icache_state_t state_q, state_d;
    logic [29:0]   miss_q, miss_d;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             fr_valid;
    logic [TAG_W-1:0] fr_tag;
    logic [31:0]      fr_data;
    logic             hit;
    logic             fill_we;
    logic             iren;

    logic unused_ok;
    assign unused_ok = ^{PC_INIT, ibus.imemaddr[1:0]};

    assign req_idx = ibus.imemaddr[1+IDX_W:2];
    assign req_tag = ibus.imemaddr[31:2+IDX_W];

    icache_frame_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_frames (
        .clk_i      (CLK),
        .rst_ni     (nRST),
        .rd_idx_i   (req_idx),
        .rd_valid_o (fr_valid),
        .rd_tag_o   (fr_tag),
        .rd_data_o  (fr_data),
        .we_i       (fill_we),
        .wr_idx_i   (miss_q[IDX_W-1:0]),
        .wr_tag_i   (miss_q[29:IDX_W]),
        .wr_data_i  (ibus.iload)
    );

    assign hit = (state_q == IDLE) && ibus.imemREN
                 && fr_valid && (fr_tag == req_tag);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= IDLE;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
        end
    end

    // Fill always completes to miss_q; the fetch side is ignored in FETCH.
    always_comb begin
        state_d = state_q;
        miss_d  = miss_q;
        fill_we = 1'b0;
        iren    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ibus.imemREN && !hit) begin
                    miss_d  = ibus.imemaddr[31:2];
                    state_d = FETCH;
                end
            end
            FETCH: begin
                iren = 1'b1;
                if (!ibus.iwait) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ibus.ihit     = hit;
    assign ibus.imemload = hit ? fr_data : 32'h0;
    assign ibus.iREN     = iren;
    assign ibus.iaddr    = word_align({miss_q, 2'b00});

endmodule

// File: tb/tb_icache.sv
// Randomized and directed bench for icache against a frame-map model.
module tb_icache;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;

    icache_if bus();

    icache #(.SETS(16), .PC_INIT(32'h0)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .ibus (bus)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: per index, which word address is cached and its data.
    logic        m_valid [16];
    logic [29:0] m_word  [16];
    logic [31:0] m_data  [16];
    logic        m_fetch;
    logic [31:0] m_miss;

    logic        last_hit;
    logic        last_iren;
    logic [31:0] last_load;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic ren,
                       input logic [31:0] a, input logic w,
                       input logic [31:0] ld);
        icachef_t f;
        icachef_t mf;
        logic     hit_e;
        @(negedge CLK);
        nRST         = rst;
        bus.imemREN  = ren;
        bus.imemaddr = a;
        bus.iwait    = w;
        bus.iload    = ld;
        #2;
        f     = a;
        hit_e = !m_fetch && ren && m_valid[f.idx]
                && (m_word[f.idx] == a[31:2]);
        check("ihit", {31'b0, bus.ihit}, {31'b0, hit_e});
        check("imemload", bus.imemload, hit_e ? m_data[f.idx] : 32'h0);
        check("iREN", {31'b0, bus.iREN}, {31'b0, m_fetch});
        check("iaddr", bus.iaddr, m_miss);
        last_hit  = bus.ihit;
        last_iren = bus.iREN;
        last_load = bus.imemload;
        @(posedge CLK);
        if (!rst) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            m_fetch = 1'b0;
            m_miss  = 32'h0;
        end else if (m_fetch) begin
            if (!w) begin
                mf = m_miss;
                m_valid[mf.idx] = 1'b1;
                m_word[mf.idx]  = m_miss[31:2];
                m_data[mf.idx]  = ld;
                m_fetch         = 1'b0;
            end
        end else if (ren && !hit_e) begin
            m_fetch = 1'b1;
            m_miss  = {a[31:2], 2'b00};
        end
    endtask

    task automatic fill(input logic [31:0] a, input logic [31:0] d,
                        input int nw);
        cyc(1'b1, 1'b1, a, 1'b1, 32'h0);
        for (int i = 0; i < nw; i++) cyc(1'b1, 1'b1, a, 1'b1, $urandom);
        cyc(1'b1, 1'b1, a, 1'b0, d);
    endtask

    initial begin
        int zc;
        int rc;
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_word[i]  = '0;
            m_data[i]  = '0;
        end
        m_fetch = 1'b0;
        m_miss  = 32'h0;
        nRST = 1'b0;
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h0;
        bus.iwait    = 1'b1;
        bus.iload    = 32'h0;
        repeat (2) @(posedge CLK);

        // Reset state
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
        check("rst_iaddr", bus.iaddr, 32'h0);

        // Miss on 0x40 with two wait cycles
        zc = 0;
        rc = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 32'h40, (i == 3) ? 1'b0 : 1'b1, 32'h2002_0005);
            if (!last_hit) zc++;
            if (last_iren) rc++;
        end
        check("miss_cycles", zc, 4);
        check("iren_cycles", rc, 3);
        cyc(1'b1, 1'b1, 32'h40, 1'b1, 32'h0);
        check("hit40", {31'b0, last_hit}, 32'h1);
        check("load40", last_load, 32'h2002_0005);

        // Byte offsets hit the same frame
        cyc(1'b1, 1'b1, 32'h42, 1'b1, 32'h0);
        cyc(1'b1, 1'b1, 32'h43, 1'b1, 32'h0);
        check("hit43", {31'b0, last_hit}, 32'h1);

        // Conflict on idx 1
        fill(32'h04, 32'hAAAA_0004, 1);
        fill(32'h44, 32'hBBBB_0044, 0);
        cyc(1'b1, 1'b1, 32'h44, 1'b1, 32'h0);
        check("hit44", last_load, 32'hBBBB_0044);
        cyc(1'b1, 1'b1, 32'h04, 1'b1, 32'h0);
        check("evict04", {31'b0, last_hit}, 32'h0);
        cyc(1'b1, 1'b1, 32'h04, 1'b0, 32'hAAAA_0004);

        // Redirect mid-fill
        cyc(1'b1, 1'b1, 32'h100, 1'b1, 32'h0);
        cyc(1'b1, 1'b1, 32'h200, 1'b1, 32'h0);
        check("redir_iaddr", bus.iaddr, 32'h100);
        cyc(1'b1, 1'b1, 32'h200, 1'b0, 32'h1111_0100);
        cyc(1'b1, 1'b1, 32'h200, 1'b1, 32'h0);
        check("redir_miss", {31'b0, last_hit}, 32'h0);
        cyc(1'b1, 1'b1, 32'h200, 1'b1, 32'h0);
        check("redir_fetch", bus.iaddr, 32'h200);
        cyc(1'b1, 1'b1, 32'h200, 1'b0, 32'h2222_0200);

        // Reset during fill of 0x80
        cyc(1'b1, 1'b1, 32'h80, 1'b1, 32'h0);
        cyc(1'b1, 1'b1, 32'h80, 1'b1, 32'h0);
        cyc(1'b0, 1'b1, 32'h80, 1'b0, 32'h3333_0080);
        cyc(1'b1, 1'b0, 32'h80, 1'b1, 32'h0);
        check("rst_fetch_iren", {31'b0, last_iren}, 32'h0);
        cyc(1'b1, 1'b1, 32'h80, 1'b1, 32'h0);
        check("rst_fetch_miss", {31'b0, last_hit}, 32'h0);
        cyc(1'b1, 1'b1, 32'h80, 1'b0, 32'h3333_0080);

        // No request with a valid frame
        fill(32'h40, 32'h4444_0040, 0);
        cyc(1'b1, 1'b0, 32'h40, 1'b1, 32'h0);
        check("noreq_hit", {31'b0, last_hit}, 32'h0);
        check("noreq_load", last_load, 32'h0);
        check("noreq_iren", {31'b0, last_iren}, 32'h0);

        // Random traffic over a small address pool
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) != 0),
                ($urandom_range(0, 7) != 0),
                (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3)),
                ($urandom_range(0, 2) != 0),
                $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
